unidade_controle_param: RTL and testbench

Parametrised multicycle control unit for the 16-bit-instruction processor: program counter, instruction register and control FSM in one block. It extends the six-instruction control unit with configurable PC, data-address and data widths; unconditional and not-zero jumps; HALT; illegal-opcode flagging; and ready-based wait states on the instruction and data memories. It drives the register file, the ALU and both memories. It contains no datapath arithmetic beyond the PC.

---
 rtl/ctrl_param_pkg.sv | 44 ++++
 rtl/unidade_controle_param_pc_reg.sv | 27 ++
 rtl/unidade_controle_param.sv | 171 +++++++++++++++++
 tb/tb_unidade_controle_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_param_pkg.sv
// rtl/ctrl_param_pkg.sv - shared states, opcodes and control encodings for unidade_controle_param
package ctrl_param_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_LOADC,
        S_SUB,
        S_JZ_TEST,
        S_JUMP,
        S_JNZ_TEST,
        S_HALT
    } statetype;

    typedef enum logic [3:0] {
        OP_MOVR  = 4'd0,
        OP_MOVD  = 4'd1,
        OP_ADD   = 4'd2,
        OP_MOVC  = 4'd3,
        OP_SUB   = 4'd4,
        OP_JMPZ  = 4'd5,
        OP_JMP   = 4'd6,
        OP_JMPNZ = 4'd7,
        OP_HALT  = 4'd8
    } opcode_t;

    localparam logic [1:0] RF_S_ALU   = 2'b00;
    localparam logic [1:0] RF_S_MEM   = 2'b01;
    localparam logic [1:0] RF_S_CONST = 2'b10;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Opcodes above HALT have no meaning and are flagged in DECODE.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_HALT;
    endfunction

endpackage

// File: rtl/unidade_controle_param_pc_reg.sv
// rtl/unidade_controle_param_pc_reg.sv - program counter with clear, increment and relative load
module pc_reg #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic            ld,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc
);

    // Clear beats increment beats load; the load subtracts one because the
    // PC has already advanced past the jump instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else if (clr)
            pc <= '0;
        else if (inc)
            pc <= pc + PC_W'(1);
        else if (ld)
            pc <= pc + offset - PC_W'(1);
    end

endmodule

// File: rtl/unidade_controle_param.sv
// rtl/unidade_controle_param.sv - multicycle control unit: PC, IR and control FSM
module unidade_controle_param
    import ctrl_param_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int D_ADDR_W = 8,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_W-1:0]     I_addr,
    output logic                I_rd,
    input  logic [15:0]         I_data,
    input  logic                I_ready,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_rd,
    output logic                D_wr,
    input  logic                D_ready,
    output logic [DATA_W-1:0]   RF_W_data,
    output logic [1:0]          RF_s,
    output logic [3:0]          RF_W_addr,
    output logic [3:0]          RF_Rp_addr,
    output logic [3:0]          RF_Rq_addr,
    output logic                RF_W_wr,
    output logic                RF_Rp_rd,
    output logic                RF_Rq_rd,
    input  logic                RF_Rp_zero,
    output logic [1:0]          alu_s,
    output logic                halted,
    output logic                illegal_op
);

    statetype          r_state;
    statetype          w_next;
    logic [15:0]       r_ir;
    logic [PC_W-1:0]   w_pc;
    logic              w_pc_clr;
    logic              w_pc_inc;
    logic              w_pc_ld;
    logic [3:0]        w_op;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [3:0]        w_rc;
    logic [7:0]        w_imm;

    assign w_op  = r_ir[15:12];
    assign w_ra  = r_ir[11:8];
    assign w_rb  = r_ir[7:4];
    assign w_rc  = r_ir[3:0];
    assign w_imm = r_ir[7:0];

    assign w_pc_clr = (r_state == S_INIT);
    assign w_pc_inc = (r_state == S_FETCH) && I_ready;
    assign w_pc_ld  = (r_state == S_JUMP);

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_pc_clr),
        .inc    (w_pc_inc),
        .ld     (w_pc_ld),
        .offset (PC_W'($signed(w_imm))),
        .pc     (w_pc)
    );

    assign I_addr = w_pc;

    // State register; reset forces INIT so every Moore output drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_INIT;
        else
            r_state <= w_next;
    end

    // Instruction register captures the word on the fetch handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ir <= '0;
        else if (w_pc_inc)
            r_ir <= I_data;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:     w_next = S_FETCH;
            S_FETCH:    w_next = I_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    OP_MOVR:  w_next = S_LOAD;
                    OP_MOVD:  w_next = S_STORE;
                    OP_ADD:   w_next = S_ADD;
                    OP_MOVC:  w_next = S_LOADC;
                    OP_SUB:   w_next = S_SUB;
                    OP_JMPZ:  w_next = S_JZ_TEST;
                    OP_JMP:   w_next = S_JUMP;
                    OP_JMPNZ: w_next = S_JNZ_TEST;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_LOAD, S_STORE: w_next = D_ready ? S_FETCH : r_state;
            S_ADD, S_LOADC, S_SUB, S_JUMP: w_next = S_FETCH;
            S_JZ_TEST:  w_next = RF_Rp_zero ? S_JUMP : S_FETCH;
            S_JNZ_TEST: w_next = RF_Rp_zero ? S_FETCH : S_JUMP;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_INIT;
        endcase
    end

    // Output decode from state and IR; only LOAD write and illegal_op see inputs/opcode.
    always_comb begin
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_W_data  = '0;
        RF_s       = RF_S_ALU;
        RF_W_addr  = '0;
        RF_Rp_addr = '0;
        RF_Rq_addr = '0;
        RF_W_wr    = 1'b0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_rd   = 1'b0;
        alu_s      = ALU_PASS;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH:  I_rd = 1'b1;
            S_DECODE: illegal_op = !is_legal(w_op);
            S_LOAD: begin
                D_addr    = D_ADDR_W'(w_imm);
                D_rd      = 1'b1;
                RF_s      = RF_S_MEM;
                RF_W_addr = w_ra;
                RF_W_wr   = D_ready;
            end
            S_STORE: begin
                D_addr     = D_ADDR_W'(w_imm);
                D_wr       = 1'b1;
                RF_Rp_addr = w_ra;
                RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Rp_addr = w_rb;
                RF_Rq_addr = w_rc;
                RF_Rp_rd   = 1'b1;
                RF_Rq_rd   = 1'b1;
                RF_W_addr  = w_ra;
                RF_W_wr    = 1'b1;
                RF_s       = RF_S_ALU;
                alu_s      = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_LOADC: begin
                RF_W_data = DATA_W'($signed(w_imm));
                RF_s      = RF_S_CONST;
                RF_W_addr = w_ra;
                RF_W_wr   = 1'b1;
            end
            S_JZ_TEST, S_JNZ_TEST: begin
                RF_Rp_addr = w_ra;
                RF_Rp_rd   = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_param.sv
// tb/tb_unidade_controle_param.sv - directed self-checking bench for unidade_controle_param
module tb_unidade_controle_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] I_addr;
    logic        I_rd;
    logic [15:0] I_data;
    logic        I_ready = 1'b1;
    logic [7:0]  D_addr;
    logic        D_rd;
    logic        D_wr;
    logic        D_ready = 1'b0;
    logic [15:0] RF_W_data;
    logic [1:0]  RF_s;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_Rp_addr;
    logic [3:0]  RF_Rq_addr;
    logic        RF_W_wr;
    logic        RF_Rp_rd;
    logic        RF_Rq_rd;
    logic        RF_Rp_zero = 1'b0;
    logic [1:0]  alu_s;
    logic        halted;
    logic        illegal_op;

    logic [15:0] imem [0:255];
    int          n_checks = 0;
    int          n_fail = 0;

    assign I_data = imem[I_addr[7:0]];

    always #5 clk = ~clk;

    unidade_controle_param #(.PC_W(16), .D_ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .I_addr(I_addr), .I_rd(I_rd), .I_data(I_data), .I_ready(I_ready),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .D_ready(D_ready),
        .RF_W_data(RF_W_data), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
        .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
        .RF_Rp_zero(RF_Rp_zero), .alu_s(alu_s),
        .halted(halted), .illegal_op(illegal_op)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) imem[i] = 16'h8000;
    endtask

    // Leaves the DUT in FETCH at PC=0, sampled at a negedge.
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({I_addr, I_rd, D_rd, D_wr, RF_W_wr, halted, illegal_op} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h rd=%b drd=%b dwr=%b wr=%b h=%b il=%b expected all 0",
                     I_addr, I_rd, D_rd, D_wr, RF_W_wr, halted, illegal_op);
        end
        reset = 1'b0;
        n_checks++;
        if (I_rd !== 1'b0) begin n_fail++; $display("FAIL init_no_fetch: got I_rd=%b expected 0", I_rd); end
        step(1);
        n_checks++;
        if (I_rd !== 1'b1 || I_addr !== 16'h0) begin
            n_fail++; $display("FAIL first_fetch: got I_rd=%b I_addr=%h expected 1/0000", I_rd, I_addr);
        end
    endtask

    task automatic test_movc_add_halt;
        clear_mem();
        imem[0] = 16'h3105;
        imem[1] = 16'h2211;
        imem[2] = 16'h8000;
        do_reset();
        step(2);
        n_checks++;
        if (RF_W_wr !== 1'b1 || RF_W_addr !== 4'd1 || RF_s !== 2'b10 || RF_W_data !== 16'h0005) begin
            n_fail++;
            $display("FAIL movc_r1: got wr=%b wa=%h s=%b data=%h expected 1/1/10/0005", RF_W_wr, RF_W_addr, RF_s, RF_W_data);
        end
        step(3);
        n_checks++;
        if (alu_s !== 2'b01 || RF_W_wr !== 1'b1 || RF_W_addr !== 4'd2 || RF_Rp_addr !== 4'd1 ||
            RF_Rq_addr !== 4'd1 || RF_Rp_rd !== 1'b1 || RF_Rq_rd !== 1'b1 || RF_s !== 2'b00) begin
            n_fail++;
            $display("FAIL add_r2: got alu=%b wr=%b wa=%h p=%h q=%h expected 01/1/2/1/1", alu_s, RF_W_wr, RF_W_addr, RF_Rp_addr, RF_Rq_addr);
        end
        n_checks++;
        if (I_addr !== 16'd2) begin n_fail++; $display("FAIL pc_after_6: got %h expected 0002", I_addr); end
        step(3);
        n_checks++;
        if (halted !== 1'b1 || I_addr !== 16'd3) begin
            n_fail++; $display("FAIL halt_enter: got halted=%b pc=%h expected 1/0003", halted, I_addr);
        end
        step(5);
        n_checks++;
        if (halted !== 1'b1 || I_addr !== 16'd3 || I_rd !== 1'b0) begin
            n_fail++; $display("FAIL halt_frozen: got halted=%b pc=%h rd=%b expected 1/0003/0", halted, I_addr, I_rd);
        end
    endtask

    task automatic test_movc_negative;
        clear_mem();
        imem[0] = 16'h33FE;
        do_reset();
        step(2);
        n_checks++;
        if (RF_W_data !== 16'hFFFE || RF_s !== 2'b10 || RF_W_addr !== 4'd3 || RF_W_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL movc_sext: got data=%h s=%b wa=%h wr=%b expected FFFE/10/3/1", RF_W_data, RF_s, RF_W_addr, RF_W_wr);
        end
    endtask

    task automatic test_load_wait;
        int wr_count;
        clear_mem();
        imem[0] = 16'h0420;
        D_ready = 1'b0;
        do_reset();
        step(2);
        wr_count = 0;
        for (int c = 0; c < 4; c++) begin
            D_ready = (c == 3);
            #1;
            n_checks++;
            if (D_rd !== 1'b1 || D_addr !== 8'h20 || RF_s !== 2'b01) begin
                n_fail++; $display("FAIL load_hold c%0d: got drd=%b addr=%h s=%b expected 1/20/01", c, D_rd, D_addr, RF_s);
            end
            if (RF_W_wr === 1'b1) begin
                wr_count++;
                n_checks++;
                if (RF_W_addr !== 4'd4) begin n_fail++; $display("FAIL load_waddr: got %h expected 4", RF_W_addr); end
            end
            step(1);
        end
        D_ready = 1'b0;
        n_checks++;
        if (wr_count !== 1) begin n_fail++; $display("FAIL load_wr_pulses: got %0d expected 1", wr_count); end
        n_checks++;
        if (D_rd !== 1'b0 || I_rd !== 1'b1 || I_addr !== 16'd1) begin
            n_fail++; $display("FAIL load_done: got drd=%b ird=%b pc=%h expected 0/1/0001", D_rd, I_rd, I_addr);
        end
    endtask

    task automatic test_fetch_wait;
        clear_mem();
        imem[0] = 16'h3105;
        do_reset();
        I_ready = 1'b0;
        step(2);
        n_checks++;
        if (I_rd !== 1'b1 || I_addr !== 16'd0) begin
            n_fail++; $display("FAIL fetch_hold: got rd=%b addr=%h expected 1/0000", I_rd, I_addr);
        end
        I_ready = 1'b1;
        step(1);
        n_checks++;
        if (I_rd !== 1'b0 || I_addr !== 16'd1) begin
            n_fail++; $display("FAIL fetch_release: got rd=%b addr=%h expected 0/0001", I_rd, I_addr);
        end
    endtask

    task automatic test_cond_jumps;
        logic [3:0] ops [4];
        logic       zs  [4];
        logic       tk  [4];
        ops = '{4'd5, 4'd5, 4'd7, 4'd7};
        zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            clear_mem();
            imem[0]  = 16'h600A;
            imem[10] = {ops[k], 4'h3, 8'hFC};
            do_reset();
            step(3);
            n_checks++;
            if (I_rd !== 1'b1 || I_addr !== 16'd10) begin
                n_fail++; $display("FAIL jmp_target: got rd=%b pc=%h expected 1/000a", I_rd, I_addr);
            end
            step(2);
            n_checks++;
            if (RF_Rp_rd !== 1'b1 || RF_Rp_addr !== 4'd3) begin
                n_fail++; $display("FAIL jtest_read case%0d: got rd=%b addr=%h expected 1/3", k, RF_Rp_rd, RF_Rp_addr);
            end
            RF_Rp_zero = zs[k];
            step(1);
            RF_Rp_zero = 1'b0;
            if (tk[k]) begin
                n_checks++;
                if (I_rd !== 1'b0) begin n_fail++; $display("FAIL jump_state case%0d: got I_rd=%b expected 0", k, I_rd); end
                step(1);
                n_checks++;
                if (I_rd !== 1'b1 || I_addr !== 16'd6) begin
                    n_fail++; $display("FAIL taken_pc case%0d: got rd=%b pc=%h expected 1/0006", k, I_rd, I_addr);
                end
            end else begin
                n_checks++;
                if (I_rd !== 1'b1 || I_addr !== 16'd11) begin
                    n_fail++; $display("FAIL nottaken_pc case%0d: got rd=%b pc=%h expected 1/000b", k, I_rd, I_addr);
                end
            end
        end
    endtask

    task automatic test_pc_wrap;
        clear_mem();
        imem[0]   = 16'h60FF;
        imem[255] = 16'h3105;
        do_reset();
        step(3);
        n_checks++;
        if (I_addr !== 16'hFFFF || I_rd !== 1'b1) begin
            n_fail++; $display("FAIL jump_back: got pc=%h rd=%b expected ffff/1", I_addr, I_rd);
        end
        step(1);
        n_checks++;
        if (I_addr !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0000", I_addr); end
    endtask

    task automatic test_illegal;
        clear_mem();
        imem[0] = 16'hA000;
        do_reset();
        step(1);
        n_checks++;
        if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", illegal_op); end
        step(1);
        n_checks++;
        if (illegal_op !== 1'b0 || I_rd !== 1'b1 || I_addr !== 16'd1) begin
            n_fail++; $display("FAIL illegal_next: got il=%b rd=%b pc=%h expected 0/1/0001", illegal_op, I_rd, I_addr);
        end
    endtask

    task automatic test_store_reset;
        clear_mem();
        imem[0] = 16'h1530;
        D_ready = 1'b0;
        do_reset();
        step(2);
        n_checks++;
        if (D_wr !== 1'b1 || D_addr !== 8'h30 || RF_Rp_addr !== 4'd5 || RF_Rp_rd !== 1'b1) begin
            n_fail++; $display("FAIL store_out: got wr=%b addr=%h p=%h rd=%b expected 1/30/5/1", D_wr, D_addr, RF_Rp_addr, RF_Rp_rd);
        end
        step(1);
        reset = 1'b1;
        #1;
        n_checks++;
        if (D_wr !== 1'b0 || I_addr !== 16'd0) begin
            n_fail++; $display("FAIL store_abort: got wr=%b pc=%h expected 0/0000", D_wr, I_addr);
        end
        step(1);
        reset = 1'b0;
        step(1);
        n_checks++;
        if (I_rd !== 1'b1 || I_addr !== 16'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL restart: got rd=%b pc=%h h=%b expected 1/0000/0", I_rd, I_addr, halted);
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_movc_add_halt();
        test_movc_negative();
        test_load_wait();
        test_fetch_wait();
        test_cond_jumps();
        test_pc_wrap();
        test_illegal();
        test_store_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
